uart_rx: RTL
============

# uart_rx

Asynchronous serial receiver (8N1) that recovers characters from a UART line and presents them as a held 8-bit parallel character plus a one-cycle valid strobe. It sits directly upstream of `rot13`: `out_char` drives `rot13.in_char`, and both blocks share the 12 MHz `clock` domain. The block also flags framing errors so the host-facing logic can count or drop bad bytes.

## Interface
- `CLKS_PER_BIT`, default 104: clock cycles per bit time; 12 MHz / 115200 baud ≈ 104. Must be ≥ 8.
- `clock`  input  1  system clock (12 MHz in the reference build).
- `reset`  input  1  asynchronous, active-low reset: asserted when 0, released synchronously by design convention upstream. One clock; reset is asynchronous and active-low.
- `rx`  input  1  serial line, idle high, asynchronous to `clock`.
- `out_char`  output  8  last correctly framed character; held until the next good frame.
- `out_valid`  output  1  one-cycle pulse when `out_char` has just been updated.
- `frame_err`  output  1  one-cycle pulse when a frame's stop bit samples low.
- `busy`  output  1  high whenever the state machine is not in IDLE.

## Operation
- Input sync: `rx` passes through two flip-flops (`rx_s`), both reset to 1. All decisions use `rx_s` only.
- Bit counter: `cnt` counts 0..CLKS_PER_BIT-1; `bit_idx` counts 0..7; `shreg` is an 8-bit shift register, LSB first.
- States:
  - IDLE: wait for `rx_s` = 0 (the prior value was 1 by construction). On detect, clear `cnt` and go to START.
  - START: at `cnt` = CLKS_PER_BIT/2 - 1 (integer divide), sample `rx_s`. If 0, clear `cnt` and `bit_idx` and go to DATA. If 1, treat as a glitch and go to IDLE with no output pulse.
  - DATA: at `cnt` = CLKS_PER_BIT-1, sample `rx_s` into `shreg[7]` while shifting right, then clear `cnt`. After `bit_idx` = 7 is sampled, go to STOP; otherwise increment `bit_idx`.
  - STOP: at `cnt` = CLKS_PER_BIT-1, sample `rx_s`.
    - If 1: load `out_char <= shreg`, pulse `out_valid`, go to IDLE. The mid-stop-bit return lets a back-to-back start bit be detected.
    - If 0: pulse `frame_err`, leave `out_char` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s` = 1, then go to IDLE. A break or stuck-low line never produces spurious frames.
- `out_valid` and `frame_err` are mutually exclusive and never high in consecutive cycles from the same frame.
- Reset, asynchronous and at any point including mid-frame: state = IDLE, `out_char` = 8'h00, `out_valid` = 0, `frame_err` = 0, `busy` = 0, `cnt` = 0, `bit_idx` = 0, `shreg` = 0, sync flops = 1. A partial frame is discarded. After release, the receiver needs a falling edge from idle-high before it starts a frame.

## Timing
- Pin to `rx_s`: 2 clock cycles.
- Let t0 be the first cycle with `rx_s` = 0 in IDLE (START is entered at t0+1).
  - Start sample: t0 + 1 + CLKS_PER_BIT/2 - 1.
  - Data bit i (i = 0..7) sample: start sample + (i+1)·CLKS_PER_BIT.
  - Stop sample: start sample + 9·CLKS_PER_BIT.
- `out_valid` and `frame_err` are registered. They are high in the single cycle after the stop sample. `out_char` changes in that same cycle.
- Downstream `rot13` registers `out_char`; its output is valid one cycle after `out_valid`.
- Throughput: back-to-back frames with zero extra idle (stop bit immediately followed by a start bit) are received without loss.
- Tolerance: correct reception at baud error up to ±3% (mid-bit sampling).
- `busy` rises the cycle START is entered and falls the cycle IDLE is re-entered.

## Test plan
- Single frame: send 8'h41 ('A') at CLKS_PER_BIT = 104 after reset release → exactly one `out_valid` pulse, `out_char` = 8'h41. Chained `rot13.out_char` = 'N' one cycle later. `frame_err` never high.
- Back-to-back: send 'a', 'z', '{' with no idle gap → three `out_valid` pulses roughly 1040 clocks apart, `out_char` = 8'h61, 8'h7A, 8'h7B in order.
- Glitch rejection: drive `rx` low for 20 clocks, then high → no `out_valid`, no `frame_err`, `busy` drops back to 0 after about 52 clocks.
- Framing error: send 8'h55 with the stop bit low and hold `rx` low for 2000 clocks, then high → one `frame_err` pulse, `out_char` keeps its previous value, no frame is started until `rx` returns high. The next good 8'h38 ('8') is received correctly.
- Reset mid-frame: assert `reset` = 0 during data bit 4 of 8'h5A, release it, then send 8'h4D ('M') → all outputs 0 during reset, no output for the aborted frame, 8'h4D is received correctly.
- Baud skew: send 8'hA5 and 8'h0F with bit times of 101 and 107 clocks (CLKS_PER_BIT = 104) → both bytes are received correctly with no `frame_err`.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver with mid-bit sampling.
// Presents a held parallel character with a one-cycle valid strobe and flags
// frames whose stop bit samples low.
module uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] out_char,
   output logic       out_valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitHigh
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic [7:0]      out_char_q, out_char_d;
   logic            out_valid_q, out_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            rx_meta_q, rx_s_q;

   // Two-flop synchronizer; resets to idle-high so reset release never looks like a start bit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Receiver state and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shreg_q     <= '0;
         out_char_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_idx_q   <= bit_idx_d;
         shreg_q     <= shreg_d;
         out_char_q  <= out_char_d;
         out_valid_q <= out_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next-state logic: start bit checked at its middle, every later bit one bit time on.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shreg_d     = shreg_q;
      out_char_d  = out_char_q;
      out_valid_d = 1'b0;
      frame_err_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (!rx_s_q) begin
               cnt_d   = '0;
               state_d = StStart;
            end
         end

         StStart: begin
            if (cnt_q == HalfLast) begin
               if (!rx_s_q) begin
                  cnt_d     = '0;
                  bit_idx_d = '0;
                  state_d   = StData;
               end else begin
                  // Line went back high before mid start bit: a glitch, not a frame.
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StData: begin
            if (cnt_q == BitLast) begin
               cnt_d   = '0;
               shreg_d = {rx_s_q, shreg_q[7:1]};
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StStop: begin
            if (cnt_q == BitLast) begin
               cnt_d = '0;
               if (rx_s_q) begin
                  // Leaving at mid stop bit leaves room to catch a back-to-back start bit.
                  out_char_d  = shreg_q;
                  out_valid_d = 1'b1;
                  state_d     = StIdle;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = StWaitHigh;
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end

         StWaitHigh: begin
            // A break or stuck-low line must not be mistaken for a stream of start bits.
            if (rx_s_q) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign out_char  = out_char_q;
   assign out_valid = out_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q != StIdle);

endmodule
